pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/sat_counter.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Contains the FSM states, the ranking of stall/flush causes, and the stage-control bundle.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FREEZE     = 2'd1,
        ST_REDIR_PEND = 2'd2
    } hz_state_e;

    // Causes are listed from lowest to highest priority.
    // A higher-ranked cause overrides every cause below it in the same cycle.
    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_ICACHE   = 3'd1,
        CAUSE_HAZARD   = 3'd2,
        CAUSE_REDIRECT = 3'd3,
        CAUSE_FREEZE   = 3'd4
    } hz_cause_e;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_bubble;
        logic ex_mem_hold;
        logic mem_wb_hold;
        logic pc_redir;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_IDLE = '0;

    localparam stage_ctrl_t CTRL_FREEZE = '{
        pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0, id_ex_hold: 1'b1,
        id_ex_bubble: 1'b0, ex_mem_hold: 1'b1, mem_wb_hold: 1'b1, pc_redir: 1'b0};

    // While a redirect waits out a cache stall, the PC mux keeps pointing at the target.
    localparam stage_ctrl_t CTRL_PEND = '{
        pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0, id_ex_hold: 1'b1,
        id_ex_bubble: 1'b0, ex_mem_hold: 1'b1, mem_wb_hold: 1'b1, pc_redir: 1'b1};

    localparam stage_ctrl_t CTRL_LOAD_USE = '{
        pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0, id_ex_hold: 1'b0,
        id_ex_bubble: 1'b1, ex_mem_hold: 1'b0, mem_wb_hold: 1'b0, pc_redir: 1'b0};

    localparam stage_ctrl_t CTRL_ICACHE = '{
        pc_hold: 1'b1, if_id_hold: 1'b0, if_id_flush: 1'b1, id_ex_hold: 1'b0,
        id_ex_bubble: 1'b0, ex_mem_hold: 1'b0, mem_wb_hold: 1'b0, pc_redir: 1'b0};

    function automatic stage_ctrl_t redirect_ctrl(input logic kill_id);
        stage_ctrl_t c;
        c              = CTRL_IDLE;
        c.pc_redir     = 1'b1;
        c.if_id_flush  = 1'b1;
        c.id_ex_bubble = kill_id;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Used for the cycle, stall and flush performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a five-stage pipeline.
// Drives stage-register holds, flushes and bubbles, and maintains the performance counters.
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter int BR_IN_ID = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_stall,
    input  logic              dcache_stall,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_branch,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_memrd,
    input  logic              redirect,
    input  logic              cnt_clr,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_bubble,
    output logic              ex_mem_hold,
    output logic              mem_wb_hold,
    output logic              pc_redir,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic BR_ID = (BR_IN_ID != 0);

    hz_state_e   state;
    hz_state_e   state_nxt;
    hz_cause_e   cause;
    stage_ctrl_t ctrl;
    logic        flush_inc;
    logic        ex_match;
    logic        mem_match;
    logic        load_use;
    logic        branch_dep;
    logic        data_hazard;
    logic        redirect_ok;

    // x0 is hard-wired to zero, so a destination of 0 never creates a dependency.
    assign ex_match  = (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_match = (mem_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));

    assign load_use    = ex_memrd && ex_match;
    assign branch_dep  = BR_ID && id_is_branch &&
                         ((ex_regwr && ex_match) || (mem_memrd && mem_match));
    assign data_hazard = load_use || branch_dep;

    // An ID-resolved branch with stale operands computed a bogus outcome; drop it.
    assign redirect_ok = redirect && !(BR_ID && data_hazard);

    always_comb begin
        cause = CAUSE_NONE;
        if (dcache_stall)      cause = CAUSE_FREEZE;
        else if (redirect_ok)  cause = CAUSE_REDIRECT;
        else if (data_hazard)  cause = CAUSE_HAZARD;
        else if (icache_stall) cause = CAUSE_ICACHE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        ctrl      = CTRL_IDLE;
        state_nxt = state;
        flush_inc = 1'b0;
        if (rst) begin
            state_nxt = ST_RUN;
        end else if (state == ST_REDIR_PEND) begin
            if (icache_stall || dcache_stall) begin
                ctrl = CTRL_PEND;
            end else begin
                ctrl      = redirect_ctrl(!BR_ID);
                flush_inc = 1'b1;
                state_nxt = ST_RUN;
            end
        end else begin
            state_nxt = ST_RUN;
            case (cause)
                CAUSE_FREEZE: begin
                    if (redirect_ok) begin
                        ctrl      = CTRL_PEND;
                        state_nxt = ST_REDIR_PEND;
                    end else begin
                        ctrl      = CTRL_FREEZE;
                        state_nxt = ST_FREEZE;
                    end
                end
                CAUSE_REDIRECT: begin
                    if (icache_stall) begin
                        ctrl      = CTRL_PEND;
                        state_nxt = ST_REDIR_PEND;
                    end else begin
                        ctrl      = redirect_ctrl(!BR_ID);
                        flush_inc = 1'b1;
                    end
                end
                CAUSE_HAZARD: ctrl = CTRL_LOAD_USE;
                CAUSE_ICACHE: ctrl = CTRL_ICACHE;
                default:      ctrl = CTRL_IDLE;
            endcase
        end
    end

    assign pc_hold      = ctrl.pc_hold;
    assign if_id_hold   = ctrl.if_id_hold;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_hold   = ctrl.id_ex_hold;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign ex_mem_hold  = ctrl.ex_mem_hold;
    assign mem_wb_hold  = ctrl.mem_wb_hold;
    assign pc_redir     = ctrl.pc_redir;

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (1'b1),
        .count (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (ctrl.pc_hold),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
